hilo_mult_ctrl: RTL and testbench

- Sits between the main control FSM and the sequential shift-add multiplier. Directly upstream of the multiplier: drives its operands and start, consumes its 64-bit product.
- Handles MULT (signed) and MULTU. Signed operands are converted to magnitude before launch; the product is sign-corrected afterwards, since the multiplier is unsigned-only.
- Owns the architectural HI/LO registers and serves MFHI/MFLO/MTHI/MTLO.

---
 rtl/mult_pkg.sv | 26 ++
 rtl/hilo_mult_ctrl_if.sv | 38 +++
 rtl/hilo_regs.sv | 67 ++++++
 rtl/hilo_mult_ctrl.sv | 153 +++++++++++++++
 tb/tb_hilo_mult_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the HI/LO multiply controller.
// Holds the controller state encoding, the default timeout, and the
// magnitude / negation helpers used around the unsigned multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT      = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    // Default number of WAIT cycles before an operation is abandoned.
    localparam int TIMEOUT_CYCLES_DEF = 40;

    // Unsigned magnitude of a two's-complement word; 0x80000000 maps to itself.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    // Two's-complement negation of a 64-bit product.
    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

endpackage

// File: rtl/hilo_mult_ctrl_if.sv
// Bus between the HI/LO controller and the sequential shift-add multiplier.
//
// Handshake: the controller raises mul_start for exactly one cycle with
// mul_a/mul_b already stable; the operands stay stable until the controller
// returns to idle. The multiplier answers by raising mul_done for at least one
// cycle with mul_hi/mul_lo valid in every cycle mul_done is high. The
// controller captures the product on the first clock edge that samples
// mul_done high and ignores mul_done at any other time.
interface hilo_mult_ctrl_if;

    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_done;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;

    // Controller side.
    modport master (
        output mul_start,
        output mul_a,
        output mul_b,
        input  mul_done,
        input  mul_hi,
        input  mul_lo
    );

    // Multiplier side.
    modport slave (
        input  mul_start,
        input  mul_a,
        input  mul_b,
        output mul_done,
        output mul_hi,
        output mul_lo
    );

endinterface

// File: rtl/hilo_regs.sv
// Architectural HI/LO registers.
// Accepts MTHI/MTLO writes only while the controller is idle, reports writes
// that arrive while an operation is in flight so they can be flagged, and
// takes the sign-corrected product during writeback.
// Optional macro HILO_BYPASS_EN: when defined, hi_out/lo_out present the
// writeback value combinationally during the writeback cycle.
module hilo_regs (
    input  logic        clock,
    input  logic        reset,
    input  logic        idle,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] wdata,
    input  logic        wb_en,
    input  logic [63:0] wb_val,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        mt_drop
);

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Next HI/LO: writeback has priority; MTHI/MTLO are honoured only when idle.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (wb_en) begin
            hi_d = wb_val[63:32];
            lo_d = wb_val[31:0];
        end else if (idle) begin
            if (mthi_we) hi_d = wdata;
            if (mtlo_we) lo_d = wdata;
        end
    end

    // A move-to while an operation is in flight is discarded and reported.
    always_comb begin
        mt_drop = ~idle & (mthi_we | mtlo_we);
    end

    // HI/LO storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

`ifdef HILO_BYPASS_EN
    // Forward the product during writeback so MFHI/MFLO in that cycle see it.
    always_comb begin
        hi_out = wb_en ? wb_val[63:32] : hi_q;
        lo_out = wb_en ? wb_val[31:0]  : lo_q;
    end
`else
    // Plain register outputs; the new value appears after the writeback edge.
    always_comb begin
        hi_out = hi_q;
        lo_out = lo_q;
    end
`endif

endmodule

// File: rtl/hilo_mult_ctrl.sv
// MULT/MULTU sequencing around an unsigned-only shift-add multiplier, plus the
// architectural HI/LO registers (MFHI/MFLO/MTHI/MTLO).
// Signed operands are launched as magnitudes and the 64-bit product is negated
// on writeback when the operand signs differ.
// Optional macro HILO_BYPASS_EN: forwards the writeback value onto
// hi_out/lo_out during the writeback cycle (see hilo_regs).
module hilo_mult_ctrl
    import mult_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W          = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    input  logic             op_signed,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    output logic             busy,
    output logic             op_done,
    output logic             op_err,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [31:0]      wdata,
    output logic [31:0]      hi_out,
    output logic [31:0]      lo_out,
    hilo_mult_ctrl_if.master mul_if,
    output state_t           dbg_state
);

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               op_done_q, op_done_d;
    logic               op_err_q, op_err_d;
    logic               mul_start_q, mul_start_d;
    logic [31:0]        mul_a_q, mul_a_d;
    logic [31:0]        mul_b_q, mul_b_d;
    logic               neg_q, neg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        prod_q, prod_d;

    logic               mt_drop;
    logic               wb_en;
    logic [63:0]        wb_val;

    // Sign-corrected product presented to HI/LO during writeback.
    always_comb begin
        wb_en  = (state_q == WRITEBACK);
        wb_val = neg_q ? neg64(prod_q) : prod_q;
    end

    // Next-state and registered-output logic of the controller FSM.
    always_comb begin
        state_d     = state_q;
        op_done_d   = 1'b0;
        op_err_d    = mt_drop;
        mul_start_d = 1'b0;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        neg_d       = neg_q;
        cnt_d       = cnt_q;
        prod_d      = prod_q;

        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    state_d     = LAUNCH;
                    mul_start_d = 1'b1;
                    mul_a_d     = op_signed ? abs32(op_a) : op_a;
                    mul_b_d     = op_signed ? abs32(op_b) : op_b;
                    neg_d       = op_signed & (op_a[31] ^ op_b[31]);
                end
            end
            LAUNCH: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A result arriving in the timeout cycle still wins.
                if (mul_if.mul_done) begin
                    state_d   = WRITEBACK;
                    prod_d    = {mul_if.mul_hi, mul_if.mul_lo};
                    op_done_d = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = IDLE;
                    op_err_d = 1'b1;
                end
            end
            WRITEBACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            op_done_q   <= 1'b0;
            op_err_q    <= 1'b0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            prod_q      <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            op_done_q   <= op_done_d;
            op_err_q    <= op_err_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            neg_q       <= neg_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
        end
    end

    hilo_regs u_hilo_regs (
        .clock   (clock),
        .reset   (reset),
        .idle    (state_q == IDLE),
        .mthi_we (mthi_we),
        .mtlo_we (mtlo_we),
        .wdata   (wdata),
        .wb_en   (wb_en),
        .wb_val  (wb_val),
        .hi_out  (hi_out),
        .lo_out  (lo_out),
        .mt_drop (mt_drop)
    );

    // Output drive.
    always_comb begin
        busy             = busy_q;
        op_done          = op_done_q;
        op_err           = op_err_q;
        mul_if.mul_start = mul_start_q;
        mul_if.mul_a     = mul_a_q;
        mul_if.mul_b     = mul_b_q;
        dbg_state        = state_q;
    end

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Bench for hilo_mult_ctrl: a behavioural multiplier answers the launch after a
// chosen number of WAIT cycles; expected HI/LO results and error pulses are
// queued when stimulus is issued and popped by an independent monitor.
module tb_hilo_mult_ctrl;
    import mult_pkg::*;

    localparam int TMO = 40;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic        op_valid, op_signed, mthi_we, mtlo_we;
    logic [31:0] op_a, op_b, wdata;
    logic        busy, op_done, op_err;
    logic [31:0] hi_out, lo_out;
    state_t      dbg_state;

    hilo_mult_ctrl_if mif ();

    hilo_mult_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(6)) dut (
        .clock     (clock),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_signed (op_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .op_done   (op_done),
        .op_err    (op_err),
        .mthi_we   (mthi_we),
        .mtlo_we   (mtlo_we),
        .wdata     (wdata),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .mul_if    (mif.master),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [31:0] due;
        logic [63:0] hilo;
        logic [63:0] prev;
    } done_t;
    typedef struct packed {
        logic [31:0] due;
        logic [63:0] hilo;
    } err_t;

    done_t done_q[$];
    err_t  err_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    logic [31:0] mdl_hi = '0, mdl_lo = '0;   // architectural HI/LO model
    logic [63:0] vis_hilo = '0;              // value visible while busy
    logic        chk_pend = 1'b0;
    logic [63:0] pend_hilo;
    done_t       mon_d;
    err_t        mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: pulse at cycle %0d, expected none", name, cyc);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_prod(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic logic [31:0] ref_mag(input bit s, input logic [31:0] a);
        if (s && $signed(a) < 0) return 32'(-longint'($signed(a)));
        return a;
    endfunction

    // ---------------- behavioural multiplier ----------------
    int          mul_delay = 0;   // 0 = never answer; k = answer in WAIT cycle k
    int          mcnt = 0;
    logic [31:0] exp_ma, exp_mb, ma, mb;

    always @(negedge clock) begin
        if (!reset) begin
            mcnt          = 0;
            mif.mul_done  = 1'b0;
            mif.mul_hi    = '0;
            mif.mul_lo    = '0;
        end else begin
            mif.mul_done = 1'b0;
            mif.mul_hi   = $urandom;
            mif.mul_lo   = $urandom;
            if (mif.mul_start) begin
                chk("mul_a", 64'(mif.mul_a), 64'(exp_ma));
                chk("mul_b", 64'(mif.mul_b), 64'(exp_mb));
                ma   = mif.mul_a;
                mb   = mif.mul_b;
                mcnt = mul_delay;
            end else if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    {mif.mul_hi, mif.mul_lo} = {32'd0, ma} * {32'd0, mb};
                    mif.mul_done = 1'b1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (reset) begin
            if (chk_pend) begin
                chk("hilo_after_done", {hi_out, lo_out}, pend_hilo);
                chk("busy_after_done", 64'(busy), 64'(0));
                chk_pend = 1'b0;
            end
            if (op_done) begin
                if (done_q.size() == 0) begin
                    unexpected("op_done");
                end else begin
                    mon_d = done_q.pop_front();
                    chk("done_latency", 64'(cyc), 64'(mon_d.due));
`ifdef HILO_BYPASS_EN
                    chk("hilo_bypass", {hi_out, lo_out}, mon_d.hilo);
`else
                    chk("hilo_hold", {hi_out, lo_out}, mon_d.prev);
`endif
                    pend_hilo = mon_d.hilo;
                    chk_pend  = 1'b1;
                end
            end
            if (op_err) begin
                if (err_q.size() == 0) begin
                    unexpected("op_err");
                end else begin
                    mon_e = err_q.pop_front();
                    chk("err_latency", 64'(cyc), 64'(mon_e.due));
                    chk("hilo_on_err", {hi_out, lo_out}, mon_e.hilo);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_mult(input bit s, input logic [31:0] a, input logic [31:0] b, input int d,
                           input bit mth, input bit mtl, input logic [31:0] wd);
        done_t       de;
        err_t        ee;
        logic [63:0] p;
        int          c0;
        @(negedge clock);
        c0        = cyc;
        op_valid  = 1'b1;
        op_signed = s;
        op_a      = a;
        op_b      = b;
        mthi_we   = mth;
        mtlo_we   = mtl;
        wdata     = wd;
        if (mth) mdl_hi = wd;
        if (mtl) mdl_lo = wd;
        vis_hilo  = {mdl_hi, mdl_lo};
        exp_ma    = ref_mag(s, a);
        exp_mb    = ref_mag(s, b);
        mul_delay = d;
        p         = ref_prod(s, a, b);
        if (d >= 1 && d <= TMO) begin
            de.due  = 32'(c0 + d + 2);
            de.hilo = p;
            de.prev = vis_hilo;
            done_q.push_back(de);
            {mdl_hi, mdl_lo} = p;
        end else begin
            ee.due  = 32'(c0 + TMO + 2);
            ee.hilo = vis_hilo;
            err_q.push_back(ee);
        end
        @(negedge clock);
        op_valid = 1'b0;
        mthi_we  = 1'b0;
        mtlo_we  = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        wdata    = $urandom;
        chk("busy_launch", 64'(busy), 64'(1));
        chk("hilo_launch", {hi_out, lo_out}, vis_hilo);
    endtask

    task automatic mt_idle(input bit mth, input bit mtl, input logic [31:0] wd);
        @(negedge clock);
        mthi_we = mth;
        mtlo_we = mtl;
        wdata   = wd;
        if (mth) mdl_hi = wd;
        if (mtl) mdl_lo = wd;
        @(negedge clock);
        mthi_we = 1'b0;
        mtlo_we = 1'b0;
        chk("mt_idle_hilo", {hi_out, lo_out}, {mdl_hi, mdl_lo});
    endtask

    task automatic mt_busy(input bit mth, input logic [31:0] wd);
        err_t ee;
        @(negedge clock);
        mthi_we = mth;
        mtlo_we = ~mth;
        wdata   = wd;
        ee.due  = 32'(cyc + 1);
        ee.hilo = vis_hilo;
        err_q.push_back(ee);
        @(negedge clock);
        mthi_we = 1'b0;
        mtlo_we = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((done_q.size() != 0 || err_q.size() != 0 || chk_pend) && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) begin
            unexpected("drain_timeout");
            done_q.delete();
            err_q.delete();
            chk_pend = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'(  $urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b0;
        op_valid  = 1'b0;
        op_signed = 1'b0;
        op_a      = '0;
        op_b      = '0;
        mthi_we   = 1'b0;
        mtlo_we   = 1'b0;
        wdata     = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy",    64'(busy),          64'(0));
        chk("rst_done",    64'(op_done),       64'(0));
        chk("rst_err",     64'(op_err),        64'(0));
        chk("rst_start",   64'(mif.mul_start), 64'(0));
        chk("rst_mul_ab",  {mif.mul_a, mif.mul_b}, 64'(0));
        chk("rst_hilo",    {hi_out, lo_out},   64'(0));
        chk("rst_state",   64'(dbg_state),     64'(IDLE));
        reset = 1'b1;
        @(negedge clock);

        // Directed cases
        do_mult(0, 32'd7, 32'd6, 34, 0, 0, 0);                       wait_idle();
        do_mult(1, 32'hFFFF_FFFD, 32'd5, 12, 0, 0, 0);               wait_idle();
        do_mult(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 0);        wait_idle();
        do_mult(1, 32'h8000_0000, 32'h8000_0000, 20, 0, 0, 0);       wait_idle();
        do_mult(1, 32'h8000_0000, 32'd1, 5, 0, 0, 0);                wait_idle();

        // Timeout keeps HI/LO; boundary at the timeout cycle
        mt_idle(1, 0, 32'h1234_5678);
        do_mult(0, 32'd3, 32'd4, 0, 0, 0, 0);                        wait_idle();
        do_mult(1, 32'd9, 32'hFFFF_FFFE, TMO, 0, 0, 0);              wait_idle();
        do_mult(0, 32'd2, 32'd2, TMO + 1, 0, 0, 0);                  wait_idle();

        // Move-to while busy is dropped; op_valid while busy is ignored
        do_mult(0, 32'd100, 32'd200, 20, 0, 0, 0);
        repeat (2) @(negedge clock);
        mt_busy(0, 32'hDEAD_BEEF);
        mt_busy(1, 32'hCAFE_F00D);
        @(negedge clock);
        op_valid = 1'b1; op_signed = 1'b1; op_a = 32'd11; op_b = 32'd13;
        @(negedge clock);
        op_valid = 1'b0;
        chk("start_while_busy", 64'(mif.mul_start), 64'(0));
        wait_idle();
        mt_idle(0, 1, 32'hDEAD_BEEF);
        mt_idle(1, 1, 32'h0BAD_F00D);

        // Move-to in the acceptance cycle is applied, then overwritten
        do_mult(1, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 8, 1, 1, 32'h5555_AAAA); wait_idle();

        // Randomised operations
        for (int i = 0; i < 24; i++) begin
            int d;
            d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TMO);
            do_mult(1'($urandom_range(0, 1)), pick32(), pick32(), d,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            wait_idle();
            if ($urandom_range(0, 3) == 0) mt_idle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end

        // Reset in the middle of WAIT aborts without op_done
        do_mult(0, 32'd5, 32'd5, 30, 0, 0, 0);
        repeat (10) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midrst_busy",  64'(busy),        64'(0));
        chk("midrst_hilo",  {hi_out, lo_out}, 64'(0));
        chk("midrst_state", 64'(dbg_state),   64'(IDLE));
        done_q.delete();
        err_q.delete();
        chk_pend = 1'b0;
        mdl_hi   = '0;
        mdl_lo   = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (45) @(negedge clock);
        chk("post_rst_hilo", {hi_out, lo_out}, 64'(0));

        do_mult(1, 32'hFFFF_FFFF, 32'd7, 3, 0, 0, 0);               wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
